// File: rtl/apb_pkg.sv
// Shared types and widths for the APB requester and its helpers.
package apb_pkg;

    localparam int unsigned APB_AW = 32;
    localparam int unsigned APB_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Transfer fields held on the bus from SETUP through the last ACCESS cycle.
    typedef struct packed {
        logic              write;
        logic [APB_AW-1:0] addr;
        logic [APB_DW-1:0] wdata;
    } apb_req_t;

endpackage

// File: rtl/apb_wait_counter.sv
// Counts PREADY wait cycles in ACCESS; flags the cycle that is the TIMEOUT-th ACCESS cycle.
module apb_wait_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count holds the number of ACCESS cycles already waited, so TIMEOUT-1 marks the last one.
    assign tc_c = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// Valid/ready command port to APB3 SETUP/ACCESS transfers across two 64-word slaves.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned SEL_BIT = 6,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [APB_AW-1:0] cmd_addr,
    input  logic [APB_DW-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [APB_DW-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL1,
    output logic              PSEL2,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [APB_AW-1:0] PADDR,
    output logic [APB_DW-1:0] PWDATA,
    input  logic [APB_DW-1:0] PRDATA1,
    input  logic [APB_DW-1:0] PRDATA2,
    input  logic              PREADY1,
    input  logic              PREADY2
);

    apb_state_e        state_q, state_d;
    apb_req_t          req_q, req_d;
    logic              sel2_q, sel2_d;
    logic              psel1_q, psel1_d;
    logic              psel2_q, psel2_d;
    logic              penable_q, penable_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [APB_DW-1:0] rsp_rdata_q, rsp_rdata_d;

    logic              cnt_clr, cnt_en, cnt_tc_c;
    logic              decode_err_c;
    logic              pready_c;
    logic [APB_DW-1:0] prdata_c;

    assign decode_err_c = |cmd_addr[APB_AW-1:SEL_BIT+1];
    assign pready_c     = sel2_q ? PREADY2 : PREADY1;
    assign prdata_c     = sel2_q ? PRDATA2 : PRDATA1;
    assign cmd_ready    = (state_q == IDLE) && !PRESET;

    apb_wait_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_counter (
        .clk (PCLK),
        .rst (PRESET),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc_c(cnt_tc_c)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        sel2_d      = sel2_q;
        psel1_d     = 1'b0;
        psel2_d     = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (decode_err_c) begin
                        // Address outside both slaves: answer immediately, bus untouched.
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d                    = SETUP;
                        req_d.write                = cmd_write;
                        req_d.addr                 = '0;
                        req_d.addr[SEL_BIT-1:0]    = cmd_addr[SEL_BIT-1:0];
                        req_d.wdata                = cmd_wdata;
                        sel2_d                     = cmd_addr[SEL_BIT];
                        psel1_d                    = !cmd_addr[SEL_BIT];
                        psel2_d                    = cmd_addr[SEL_BIT];
                        cnt_clr                    = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                psel1_d   = !sel2_q;
                psel2_d   = sel2_q;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (pready_c) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = req_q.write ? '0 : prdata_c;
                end else if (cnt_tc_c) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_en    = 1'b1;
                    psel1_d   = !sel2_q;
                    psel2_d   = sel2_q;
                    penable_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            req_q       <= '0;
            sel2_q      <= 1'b0;
            psel1_q     <= 1'b0;
            psel2_q     <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            sel2_q      <= sel2_d;
            psel1_q     <= psel1_d;
            psel2_q     <= psel2_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign PSEL1     = psel1_q;
    assign PSEL2     = psel2_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = req_q.write;
    assign PADDR     = req_q.addr;
    assign PWDATA    = req_q.wdata;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/apb_master.md
# apb_master

APB requester that converts a simple valid/ready command port into APB3-style SETUP/ACCESS transfers toward the two 64-word APB memory slaves on the bus. It decodes the command address into one of two PSEL lines, drives the local word offset on PADDR, waits on the selected slave's PREADY, and returns a one-cycle response carrying read data or an error. Transfers that stall too long and addresses outside both slaves terminate with an error response.

## Interface
- SEL_BIT, 6: address bit selecting the slave (0 → slave 1, 1 → slave 2); bits [SEL_BIT-1:0] form the slave-local offset.
- TIMEOUT, 16: maximum ACCESS cycles waited for PREADY before aborting (≥2).

- PCLK  in  1  bus clock; all logic on rising edge.
- PRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command (high only in IDLE, low while PRESET high).
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  word address.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  read data (0 for writes and errors).
- rsp_err  out  1  timeout or decode error.
- PSEL1, PSEL2  out  1  slave selects.
- PENABLE  out  1  ACCESS phase.
- PWRITE  out  1  transfer direction.
- PADDR  out  32  local offset, zero-extended.
- PWDATA  out  32  write data.
- PRDATA1, PRDATA2  in  32  slave read data.
- PREADY1, PREADY2  in  1  slave ready.

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready=1. Handshake (cmd_valid & cmd_ready) latches write/addr/wdata.
  - cmd_addr[31:SEL_BIT+1] nonzero → decode error: no PSEL asserted, remain IDLE, response next cycle with rsp_err=1, rsp_rdata=0.
  - Otherwise → SETUP; PADDR = {0, cmd_addr[SEL_BIT-1:0]}, PWRITE, PWDATA loaded.
- SETUP: selected PSELx=1, PENABLE=0; unconditionally → ACCESS.
- ACCESS: PSELx=1, PENABLE=1. Only the selected slave's PREADY/PRDATA are observed.
  - PREADY=1 → capture PRDATA (reads only), → IDLE, response next cycle with rsp_err=0.
  - PREADY=0 → wait counter increments; if PREADY still 0 in the TIMEOUT-th ACCESS cycle → → IDLE, response with rsp_err=1, rsp_rdata=0.
- Wait counter clears on entry to SETUP; width $clog2(TIMEOUT+1).
- PADDR, PWRITE, PWDATA stable from SETUP through the last ACCESS cycle; they hold their last values in IDLE (not zeroed).
- Reset values (asserted on the edge PRESET is sampled high, from any state): state IDLE, PSEL1/PSEL2/PENABLE/PWRITE=0, PADDR/PWDATA=0, rsp_valid/rsp_err=0, rsp_rdata=0. Reset mid-transfer aborts without a response.

## Timing
- Registered outputs except cmd_ready (decoded from state, gated by PRESET).
- Zero-wait transfer: accept at edge N, SETUP in cycle N+1, ACCESS in N+2, rsp_valid in N+3. Each PREADY wait cycle adds one.
- rsp_valid is asserted in the first IDLE cycle after completion, for exactly one cycle. A new command can be accepted in that same cycle, so back-to-back transfers have one IDLE cycle between ACCESS and the next SETUP.
- Decode-error response: rsp_valid one cycle after the handshake; cmd_ready stays high.
- PENABLE is never high without a PSEL. PSEL1 and PSEL2 are never both high.

## Structure
- apb_pkg: state enum (IDLE, SETUP, ACCESS), APB_AW=32, APB_DW=32.
- One sub-module: apb_wait_counter (clear, enable, terminal-count flag at TIMEOUT).

## Test plan
- PRESET high for 2 cycles during an ACCESS → PSEL1=PSEL2=PENABLE=0, all rsp_* =0, no rsp_valid afterwards.
- Write addr 0x05, data 0xDEADBEEF, PREADY1 tied 1 → PSEL1 for 2 cycles (PENABLE in the 2nd), PADDR=0x05, rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read addr 0x45, PRDATA2=0x12345678, PREADY2 low for 3 ACCESS cycles → PADDR=0x05 stable for 5 cycles, rsp_rdata=0x12345678, rsp_valid 6 cycles after accept.
- PREADY1 held 0 on a read at 0x10 → exactly 16 ACCESS cycles, then PSEL1 drops, rsp_err=1, rsp_rdata=0.
- Command at addr 0x80 → no PSEL ever asserted, rsp_valid with rsp_err=1 one cycle after accept.
- Two back-to-back writes (0x01, then 0x41) with cmd_valid held → second accepted in the first rsp_valid cycle, PSEL2 SETUP in the next cycle.
